// File: rtl/seq_chunk_adder_pkg.sv
// Shared types for the sequential chunked adder/subtractor.
// Mode bit 0 selects subtraction; bit 1 selects saturation.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ADD_WRAP = 2'b00,
        SUB_WRAP = 2'b01,
        ADD_SAT  = 2'b10,
        SUB_SAT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_chunk_adder_slice.sv
// Combinational W-bit adder slice with carry in/out.
// This is the only adder in the block; it is reused once per chunk.
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/sub built from one CHUNK-bit slice and a
// carry register, with wrap or unsigned-saturate modes and valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// CALC  | one chunk per cycle through the slice, carry held in cy_q
// DONE  | out_valid high, result held until out_ready
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             cy_q;

    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_cout;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;
    logic             last;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                sl_a = a_q[i*CHUNK +: CHUNK];
                sl_b = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    adder_slice #(.W(CHUNK)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (cy_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    // Full result including the chunk being written this cycle, so the final
    // saturation decision can register straight into sum on the last edge.
    always_comb begin
        res_d = res_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                res_d[i*CHUNK +: CHUNK] = sl_s;
            end
        end
    end

    assign last  = (idx_q == IDXW'(NCHUNK - 1));
    assign ovf_d = mode_q[0] ? ~sl_cout : sl_cout;

    always_comb begin
        sum_d = res_d;
        if (ovf_d && mode_q == ADD_SAT) sum_d = '1;
        if (ovf_d && mode_q == SUB_SAT) sum_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cy_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            mode_q <= ADD_WRAP;
            sum    <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= mode[0] ? ~b : b;
                        cy_q   <= mode[0];
                        mode_q <= mode_e'(mode);
                        idx_q  <= '0;
                        res_q  <= '0;
                    end
                end
                CALC: begin
                    res_q <= res_d;
                    cy_q  <= sl_cout;
                    idx_q <= idx_q + 1'b1;
                    if (last) begin
                        sum   <= sum_d;
                        carry <= sl_cout;
                        ovf   <= ovf_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 32/8 and 8/8 instances, scoreboard
// queues filled at acceptance and drained when out_valid appears.
module tb_seq_chunk_adder;
    import seq_chunk_adder_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } exp32_t;

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } exp8_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv, ir, ov, ordy, cy, ovf;
    logic [31:0] a, b, sum;
    logic [1:0]  md;
    logic        iv8, ir8, ov8, ordy8, cy8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic [1:0]  md8;

    int tests = 0;
    int fails = 0;
    exp32_t q32[$];
    exp8_t  q8[$];
    exp32_t last32;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .mode(md), .out_valid(ov), .out_ready(ordy), .sum(sum), .carry(cy), .ovf(ovf)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .mode(md8), .out_valid(ov8), .out_ready(ordy8), .sum(sum8), .carry(cy8), .ovf(ovf8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp32_t model32(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        exp32_t      e;
        logic [32:0] t;
        if (!m[0]) begin
            t       = {1'b0, x} + {1'b0, y};
            e.sum   = t[31:0];
            e.carry = t[32];
            e.ovf   = t[32];
        end else begin
            e.sum   = x - y;
            e.carry = (x >= y);
            e.ovf   = (x < y);
        end
        if (m == 2'b10 && e.ovf) e.sum = 32'hFFFF_FFFF;
        if (m == 2'b11 && e.ovf) e.sum = 32'h0;
        return e;
    endfunction

    function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
        exp8_t      e;
        logic [8:0] t;
        if (!m[0]) begin
            t       = {1'b0, x} + {1'b0, y};
            e.sum   = t[7:0];
            e.carry = t[8];
            e.ovf   = t[8];
        end else begin
            e.sum   = x - y;
            e.carry = (x >= y);
            e.ovf   = (x < y);
        end
        if (m == 2'b10 && e.ovf) e.sum = 8'hFF;
        if (m == 2'b11 && e.ovf) e.sum = 8'h0;
        return e;
    endfunction

    task automatic start32(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        int n = 0;
        while (!ir && n < 100) begin tick(); n++; end
        a = x; b = y; md = m; iv = 1'b1;
        q32.push_back(model32(x, y, m));
        tick();
        // scramble inputs after acceptance; the DUT must not re-sample them
        iv = 1'b0; a = ~x; b = ~y; md = ~m;
    endtask

    task automatic collect32(input string tag);
        int n = 0;
        while (!ov && n < 50) begin tick(); n++; end
        check({tag, " latency"}, 64'(n), 64'd4);
        check({tag, " queue"}, 64'(q32.size()), 64'd1);
        if (q32.size() != 0) last32 = q32.pop_front();
        check({tag, " sum"}, 64'(sum), 64'(last32.sum));
        check({tag, " carry"}, 64'(cy), 64'(last32.carry));
        check({tag, " ovf"}, 64'(ovf), 64'(last32.ovf));
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m, input string tag);
        start32(x, y, m);
        collect32(tag);
        tick();
        check({tag, " back to idle"}, 64'({ov, ir}), 64'b01);
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m, input string tag);
        exp8_t e;
        int    n = 0;
        while (!ir8 && n < 100) begin tick(); n++; end
        a8 = x; b8 = y; md8 = m; iv8 = 1'b1;
        q8.push_back(model8(x, y, m));
        tick();
        iv8 = 1'b0; a8 = ~x; b8 = ~y; md8 = ~m;
        n = 0;
        while (!ov8 && n < 50) begin tick(); n++; end
        check({tag, " latency"}, 64'(n), 64'd1);
        check({tag, " queue"}, 64'(q8.size()), 64'd1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check({tag, " sum"}, 64'(sum8), 64'(e.sum));
            check({tag, " carry"}, 64'(cy8), 64'(e.carry));
            check({tag, " ovf"}, 64'(ovf8), 64'(e.ovf));
        end
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        iv = 1'b0; a = '0; b = '0; md = '0; ordy = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; md8 = '0; ordy8 = 1'b1;
        #12;
        check("reset ready/valid", 64'({ir, ov}), 64'b10);
        check("reset sum/cy/ovf", 64'({sum, cy, ovf}), 64'd0);
        check("reset8 ready/valid", 64'({ir8, ov8}), 64'b10);
        check("reset8 sum/cy/ovf", 64'({sum8, cy8, ovf8}), 64'd0);
        #10 rst_n = 1'b1;
        tick();

        run32(32'hFFFF_FFFF, 32'h0000_0001, ADD_WRAP, "addw wrap");
        run32(32'h0000_00FF, 32'h0000_0001, ADD_WRAP, "addw chunk carry");
        run32(32'h0000_0000, 32'h0000_0001, SUB_WRAP, "subw borrow");
        run32(32'h8000_0000, 32'h8000_0000, ADD_SAT, "adds clamp");
        run32(32'd5, 32'd7, SUB_SAT, "subs clamp");
        run32(32'd7, 32'd5, SUB_SAT, "subs plain");
        for (int k = 0; k < 6; k++) begin
            run32($urandom, $urandom, 2'($urandom_range(0, 3)), "random");
        end

        // backpressure: result must hold and input requests must be ignored
        ordy = 1'b0;
        start32(32'h0000_0009, 32'h0000_000C, SUB_SAT);
        collect32("bp");
        for (int k = 0; k < 10; k++) begin
            iv = (k % 2 == 0);
            a = $urandom; b = $urandom; md = ADD_WRAP;
            tick();
            check("bp hold sum", 64'(sum), 64'(last32.sum));
            check("bp hold cy/ovf", 64'({cy, ovf}), 64'({last32.carry, last32.ovf}));
            check("bp valid/ready", 64'({ov, ir}), 64'b10);
        end
        iv = 1'b0;
        ordy = 1'b1;
        tick();
        check("bp release", 64'({ov, ir}), 64'b01);
        seen = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (ov) seen++; end
        check("bp no ghost op", 64'(seen), 64'd0);

        // reset while idx=2 discards the operation
        start32(32'hDEAD_BEEF, 32'h0101_0101, ADD_WRAP);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset ready/valid", 64'({ir, ov}), 64'b10);
        check("midreset sum", 64'(sum), 64'd0);
        q32.delete();
        #3 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (ov) seen++; end
        check("midreset no valid", 64'(seen), 64'd0);
        run32(32'h1234_5678, 32'h1111_1111, ADD_WRAP, "after reset");
        check("after reset const", 64'(last32.sum), 64'h2345_6789);

        run8(8'h7F, 8'h01, ADD_WRAP, "w8 addw");
        run8(8'hFF, 8'h01, ADD_SAT, "w8 adds");
        run8(8'h03, 8'h05, SUB_SAT, "w8 subs");
        run8(8'h90, 8'h20, SUB_WRAP, "w8 subw");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
